spiker_sequencer: RTL and testbench
===================================

# spiker_sequencer

Controller that sequences one inference frame through the spike reader core. It fetches the packed spike words from the adapter register file one word per cycle into a frame buffer. It hands the full frame to the core with a valid/ready handshake, waits for the core's completion, and writes the result frame back to the register file word by word. It reports busy, done, timeout and an interrupt pulse. It sits between the register file and the spiker_reader core, replacing the static word-to-bus wiring.

## Interface
- WIDTH, 32: register word width in bits
- N_SPIKES, 784: spikes per frame; N_WORDS = ceil(N_SPIKES/WIDTH) = 25 by default
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before the frame is abandoned; must be ≥1
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous and active-high
- start_i  in  1  one-cycle start request (register qe)
- abort_i  in  1  cancel the current frame
- spike_addr_o  out  clog2(N_WORDS)  spike word index being read
- spike_word_i  in  WIDTH  spike word at spike_addr_o, combinational same-cycle read
- core_data_o  out  N_SPIKES  frame presented to the core
- core_valid_o  out  1  frame valid
- core_ready_i  in  1  core accepts the frame
- core_done_i  in  1  one-cycle pulse: core_result_i is valid
- core_result_i  in  N_SPIKES  result frame
- res_addr_o  out  clog2(N_WORDS)  result word index
- res_word_o  out  WIDTH  result word
- res_we_o  out  1  result write enable (d/de style)
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  sticky; set at FINISH, cleared by an accepted start
- timeout_o  out  1  sticky; set on timeout, cleared by an accepted start
- irq_o  out  1  one-cycle pulse at FINISH

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, STORE, FINISH.
- IDLE:
  - start_i=1 with abort_i=0 clears done_o and timeout_o and goes to LOAD.
  - start_i in any other state is ignored.
- LOAD:
  - Runs N_WORDS cycles; spike_addr_o = 0..N_WORDS-1.
  - Each cycle, spike_word_i is written into frame buffer word [addr].
  - In the last word, bits at frame positions ≥ N_SPIKES are dropped.
  - Moves to ISSUE after word N_WORDS-1.
- ISSUE:
  - core_valid_o=1, held until core_valid_o and core_ready_i are both high in the same cycle.
  - Then goes to WAIT and clears the wait counter.
- WAIT:
  - The counter increments each cycle.
  - core_done_i=1 captures core_result_i into the result buffer and goes to STORE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES, sets timeout_o and goes to FINISH without writing results.
  - If core_done_i and the timeout fall in the same cycle, done wins.
  - core_done_i outside WAIT is ignored.
- STORE:
  - Runs N_WORDS cycles, with res_we_o=1 and res_addr_o = 0..N_WORDS-1.
  - res_word_o is result buffer word [addr]; pad bits of the last word are 0.
- FINISH: one cycle; irq_o=1 and done_o set; then IDLE.
- Abort:
  - abort_i=1 in any non-IDLE state returns to IDLE next cycle.
  - core_valid_o and res_we_o drop in that next cycle.
  - done_o, irq_o and timeout_o are not touched.
  - Abort has priority over every other transition, including start in IDLE.
- core_data_o always reflects the frame buffer; it is stable from ISSUE entry until the next LOAD.
- Wait counter width is clog2(TIMEOUT_CYCLES+1); it never wraps.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including spike_addr_o, res_addr_o and res_word_o.
  - Frame and result buffers 0.
- Reset mid-frame behaves like abort, and additionally clears done_o and timeout_o.
- Let start_i be high in cycle k.
  - LOAD runs in cycles k+1..k+N_WORDS.
  - ISSUE begins in cycle k+N_WORDS+1.
  - If core_ready_i is already high, the handshake happens in that cycle and WAIT begins in k+N_WORDS+2.
- Let core_done_i arrive in WAIT cycle d.
  - STORE writes run in cycles d+1..d+N_WORDS.
  - FINISH (irq_o) is in d+N_WORDS+1.
  - busy_o falls in d+N_WORDS+2.
- Timeout: FINISH occurs in the cycle after the counter equals TIMEOUT_CYCLES.
- All outputs are registered except spike_addr_o and res_addr_o, which decode from state and the word counter.

## Structure
- Package spiker_sequencer_pkg holds:
  - the state enum type;
  - the N_WORDS and address-width localparams, as functions of WIDTH and N_SPIKES.
- One sub-module, spiker_frame_buf: N_WORDS×WIDTH word-write / full-width-read buffer with pad masking.
  - Instantiated twice: once for spikes and once for results.
  - The result instance uses full-width write and word read.

## Test plan
- Basic frame:
  - Stimulus: spike words = 32'hA5A5_0000+i; core with ready=1 and done 5 cycles after the handshake, result = ~data.
  - Required: 25 res_we_o writes with res_word_o = ~(spike word i); last word upper 16 bits = 0; single irq_o at the cycle computed above; done_o=1.
- Backpressure:
  - Stimulus: core_ready_i low for 7 ISSUE cycles.
  - Required: core_valid_o held high with core_data_o unchanged; exactly one handshake.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, core never asserts done.
  - Required: timeout_o=1, no res_we_o, irq_o pulse, done_o=1.
  - Follow-up: the next start clears both flags.
- Done on timeout edge:
  - Stimulus: core_done_i in the same cycle the counter hits 16.
  - Required: STORE runs and timeout_o=0.
- Abort and restart:
  - Stimulus: abort_i during LOAD word 10, then during STORE word 3; start_i while busy.
  - Required: IDLE next cycle; no further writes; no irq_o; start while busy has no effect.
- Reset mid-WAIT:
  - Stimulus: rst_i=1 for one cycle during WAIT.
  - Required: all outputs 0 next cycle; a subsequent frame completes normally.

Source files
------------

// File: rtl/spiker_sequencer_pkg.sv
// Shared types and sizing helpers for the spiker_sequencer frame controller
// and its frame buffers.
package spiker_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_FINISH
    } state_e;

    function automatic int n_words_of(input int width, input int n_spikes);
        return (n_spikes + width - 1) / width;
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_N_SPIKES = 784;
    localparam int DEF_N_WORDS  = n_words_of(DEF_WIDTH, DEF_N_SPIKES);
    localparam int DEF_ADDR_W   = idx_w(DEF_N_WORDS);

endpackage

// File: rtl/spiker_frame_buf.sv
// N_SPIKES-bit frame store. WORD_WRITE=1: word write, full-width read.
// WORD_WRITE=0: full-width write, word read with zeroed pad bits.
module spiker_frame_buf import spiker_sequencer_pkg::*; #(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int N_SPIKES   = DEF_N_SPIKES,
    parameter bit WORD_WRITE = 1'b1,
    localparam int N_WORDS   = n_words_of(WIDTH, N_SPIKES),
    localparam int ADDR_W    = idx_w(N_WORDS),
    localparam int WR_W      = WORD_WRITE ? WIDTH : N_SPIKES,
    localparam int RD_W      = WORD_WRITE ? N_SPIKES : WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WR_W-1:0]   wdata_i,
    output logic [RD_W-1:0]   rdata_o
);

    localparam int PAD_W  = N_WORDS * WIDTH;
    localparam int MIDX_W = idx_w(N_SPIKES);
    localparam int PIDX_W = idx_w(PAD_W);

    logic [N_SPIKES-1:0] mem;
    logic [N_SPIKES-1:0] nxt_mem;

    generate
        if (WORD_WRITE) begin : g_word_wr
            // Bits of the last word that fall past N_SPIKES have no storage and are dropped.
            always_comb begin
                nxt_mem = mem;
                if (we_i) begin
                    for (int b = 0; b < WIDTH; b++) begin
                        if (int'(addr_i) * WIDTH + b < N_SPIKES)
                            nxt_mem[MIDX_W'(int'(addr_i) * WIDTH + b)] = wdata_i[b];
                    end
                end
            end
            assign rdata_o = mem;
        end else begin : g_full_wr
            logic [PAD_W-1:0] rd_pad;
            // NOTE: the word read sees this cycle's write, so a result captured on
            // one edge can be registered out as word 0 on the very next edge.
            always_comb begin
                nxt_mem = we_i ? wdata_i : mem;
                rd_pad  = '0;
                rd_pad[N_SPIKES-1:0] = nxt_mem;
            end
            assign rdata_o = rd_pad[PIDX_W'(int'(addr_i) * WIDTH) +: WIDTH];
        end
    endgenerate

    // NOTE: the buffer is a flop array, not a RAM macro, so it can take the
    // reset and come up as an all-zero frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) mem <= '0;
        else       mem <= nxt_mem;
    end

endmodule

// File: rtl/spiker_sequencer.sv
// Sequences one inference frame: load spike words, hand the frame to the core,
// wait for its result, and write the result back word by word.
module spiker_sequencer import spiker_sequencer_pkg::*; #(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int N_SPIKES       = DEF_N_SPIKES,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int N_WORDS       = n_words_of(WIDTH, N_SPIKES),
    localparam int ADDR_W        = idx_w(N_WORDS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic [ADDR_W-1:0]   spike_addr_o,
    input  logic [WIDTH-1:0]    spike_word_i,
    output logic [N_SPIKES-1:0] core_data_o,
    output logic                core_valid_o,
    input  logic                core_ready_i,
    input  logic                core_done_i,
    input  logic [N_SPIKES-1:0] core_result_i,
    output logic [ADDR_W-1:0]   res_addr_o,
    output logic [WIDTH-1:0]    res_word_o,
    output logic                res_we_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                timeout_o,
    output logic                irq_o
);

    localparam int                WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(N_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    state_e            state;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] res_rd_addr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WIDTH-1:0]  res_rword;

    assign spike_addr_o = (state == ST_LOAD)  ? word_cnt : '0;
    assign res_addr_o   = (state == ST_STORE) ? word_cnt : '0;

    // res_word_o is registered, so the result buffer is read one word ahead.
    always_comb begin
        res_rd_addr = '0;
        if (state == ST_STORE && word_cnt != LAST_WORD)
            res_rd_addr = word_cnt + ADDR_W'(1);
    end

    spiker_frame_buf #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES), .WORD_WRITE(1'b1)) u_spike_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (state == ST_LOAD),
        .addr_i  (word_cnt),
        .wdata_i (spike_word_i),
        .rdata_o (core_data_o)
    );

    spiker_frame_buf #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES), .WORD_WRITE(1'b0)) u_result_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (state == ST_WAIT && core_done_i),
        .addr_i  (res_rd_addr),
        .wdata_i (core_result_i),
        .rdata_o (res_rword)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            word_cnt     <= '0;
            wait_cnt     <= '0;
            core_valid_o <= 1'b0;
            res_we_o     <= 1'b0;
            res_word_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            irq_o <= 1'b0;
            if (abort_i && state != ST_IDLE) begin
                // Abort leaves done/timeout alone; it only drops the frame.
                state        <= ST_IDLE;
                word_cnt     <= '0;
                core_valid_o <= 1'b0;
                res_we_o     <= 1'b0;
                res_word_o   <= '0;
                busy_o       <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            state     <= ST_LOAD;
                            word_cnt  <= '0;
                            busy_o    <= 1'b1;
                            done_o    <= 1'b0;
                            timeout_o <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        if (word_cnt == LAST_WORD) begin
                            state        <= ST_ISSUE;
                            word_cnt     <= '0;
                            core_valid_o <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + ADDR_W'(1);
                        end
                    end
                    ST_ISSUE: begin
                        if (core_ready_i) begin
                            state        <= ST_WAIT;
                            core_valid_o <= 1'b0;
                            wait_cnt     <= '0;
                        end
                    end
                    ST_WAIT: begin
                        // A result in the limit cycle still counts as a completed frame.
                        if (core_done_i) begin
                            state      <= ST_STORE;
                            word_cnt   <= '0;
                            res_we_o   <= 1'b1;
                            res_word_o <= res_rword;
                        end else if (wait_cnt == WAIT_LIMIT) begin
                            state     <= ST_FINISH;
                            timeout_o <= 1'b1;
                            done_o    <= 1'b1;
                            irq_o     <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    ST_STORE: begin
                        if (word_cnt == LAST_WORD) begin
                            state      <= ST_FINISH;
                            word_cnt   <= '0;
                            res_we_o   <= 1'b0;
                            res_word_o <= '0;
                            done_o     <= 1'b1;
                            irq_o      <= 1'b1;
                        end else begin
                            word_cnt   <= word_cnt + ADDR_W'(1);
                            res_word_o <= res_rword;
                        end
                    end
                    ST_FINISH: begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spiker_sequencer.sv
// Directed bench for spiker_sequencer: a table of complete frames with varied
// core timing, plus hand-written abort, busy-start and reset sequences.
module tb_spiker_sequencer;

    localparam int WIDTH    = 32;
    localparam int N_SPIKES = 784;
    localparam int N_WORDS  = 25;
    localparam int ADDR_W   = 5;
    localparam int TMO      = 16;

    logic                clk = 1'b0;
    logic                rst_i, start_i, abort_i;
    logic [ADDR_W-1:0]   spike_addr_o, res_addr_o;
    logic [WIDTH-1:0]    spike_word_i, res_word_o;
    logic [N_SPIKES-1:0] core_data_o, core_result_i;
    logic                core_valid_o, core_ready_i, core_done_i;
    logic                res_we_o, busy_o, done_o, timeout_o, irq_o;

    spiker_sequencer #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .spike_addr_o  (spike_addr_o),
        .spike_word_i  (spike_word_i),
        .core_data_o   (core_data_o),
        .core_valid_o  (core_valid_o),
        .core_ready_i  (core_ready_i),
        .core_done_i   (core_done_i),
        .core_result_i (core_result_i),
        .res_addr_o    (res_addr_o),
        .res_word_o    (res_word_o),
        .res_we_o      (res_we_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .timeout_o     (timeout_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file and core stand-ins.
    assign spike_word_i  = 32'hA5A5_0000 + 32'(spike_addr_o);
    assign core_result_i = ~core_data_o;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  word;
    } wr_t;
    wr_t wr_log[$];
    always @(negedge clk) if (res_we_o) wr_log.push_back({res_addr_o, res_word_o});

    typedef struct {
        string name;
        int    ready_delay;  // ISSUE cycles with ready low
        int    done_after;   // done_i this many cycles after the handshake; -1 never
        int    exp_writes;
        bit    exp_timeout;
        int    exp_irq_off;  // irq cycle minus handshake cycle
    } vec_t;

    vec_t                vecs[7];
    logic [WIDTH-1:0]    exp_words[N_WORDS];
    logic [N_SPIKES-1:0] exp_frame;
    int                  n_checks = 0;
    int                  n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int k, first_issue, hs_cyc, irq_cyc, busy_fall;
        int n_irq, n_hs, n_issue, bad_data, bad_wr;
        bit finished;
        first_issue = -1; hs_cyc = -1; irq_cyc = -1; busy_fall = -1;
        n_irq = 0; n_hs = 0; n_issue = 0; bad_data = 0; bad_wr = 0; finished = 1'b0;
        wr_log.delete();
        start_i = 1'b1;
        k = cyc;
        step();
        start_i = 1'b0;
        check({v.name, ":load_entry"}, {busy_o, done_o, timeout_o, spike_addr_o},
              {1'b1, 1'b0, 1'b0, 5'd0});
        for (int t = 0; t < 300 && !finished; t++) begin
            core_ready_i = 1'b0;
            core_done_i  = 1'b0;
            if (irq_o) begin
                n_irq++;
                irq_cyc = cyc;
            end
            if (!busy_o) begin
                finished  = 1'b1;
                busy_fall = cyc;
            end else begin
                if (core_valid_o) begin
                    if (n_issue == 0) first_issue = cyc;
                    if (core_data_o !== exp_frame) bad_data++;
                    if (n_issue >= v.ready_delay) begin
                        core_ready_i = 1'b1;
                        n_hs++;
                        hs_cyc = cyc;
                    end
                    n_issue++;
                end else if (n_hs > 0 && v.done_after > 0 && cyc == hs_cyc + v.done_after) begin
                    core_done_i = 1'b1;
                end
                step();
            end
        end
        check({v.name, ":finished"},    finished, 1);
        check({v.name, ":issue_cycle"}, first_issue, k + N_WORDS + 1);
        check({v.name, ":handshakes"},  n_hs, 1);
        check({v.name, ":hs_cycle"},    hs_cyc, first_issue + v.ready_delay);
        check({v.name, ":frame_data"},  bad_data, 0);
        check({v.name, ":irq_count"},   n_irq, 1);
        check({v.name, ":irq_cycle"},   irq_cyc, hs_cyc + v.exp_irq_off);
        check({v.name, ":busy_fall"},   busy_fall, irq_cyc + 1);
        check({v.name, ":writes"},      wr_log.size(), v.exp_writes);
        for (int j = 0; j < wr_log.size() && j < N_WORDS; j++)
            if (wr_log[j].addr != ADDR_W'(j) || wr_log[j].word !== exp_words[j]) bad_wr++;
        check({v.name, ":write_data"},  bad_wr, 0);
        if (wr_log.size() == N_WORDS)
            check({v.name, ":last_pad"}, wr_log[N_WORDS-1].word[31:16], 0);
        check({v.name, ":flags"}, {done_o, timeout_o, core_valid_o}, {1'b1, v.exp_timeout, 1'b0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench stalled");
        $fatal(1);
    end

    initial begin
        int hs, quiet;
        logic [N_WORDS*WIDTH-1:0] frame_pad;

        for (int i = 0; i < N_WORDS; i++) begin
            frame_pad[i*WIDTH +: WIDTH] = 32'hA5A5_0000 + 32'(i);
            exp_words[i] = ~(32'hA5A5_0000 + 32'(i));
        end
        exp_words[N_WORDS-1][31:16] = 16'h0000;
        exp_frame = frame_pad[N_SPIKES-1:0];

        vecs[0] = '{"basic",        0,  5, 25, 1'b0, 31};
        vecs[1] = '{"backpressure", 7,  5, 25, 1'b0, 31};
        vecs[2] = '{"timeout",      0, -1,  0, 1'b1, 18};
        vecs[3] = '{"after_tmo",    2,  5, 25, 1'b0, 31};
        vecs[4] = '{"done_on_edge", 0, 17, 25, 1'b0, 43};
        vecs[5] = '{"done_early",   1, 16, 25, 1'b0, 42};
        vecs[6] = '{"done_late",    3, 18,  0, 1'b1, 18};

        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        core_ready_i = 1'b0; core_done_i = 1'b0;
        repeat (3) step();
        check("reset_outputs",
              {busy_o, core_valid_o, res_we_o, irq_o, done_o, timeout_o, spike_addr_o, res_addr_o, res_word_o}, 0);
        check("reset_frame", |core_data_o, 0);
        rst_i = 1'b0;
        step();

        // Abort wins over start in IDLE.
        start_i = 1'b1; abort_i = 1'b1;
        step();
        start_i = 1'b0; abort_i = 1'b0;
        check("start_with_abort", {busy_o, spike_addr_o}, 0);

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Start while busy is ignored, then abort in LOAD word 10.
        wr_log.delete();
        start_i = 1'b1; step(); start_i = 1'b0;
        repeat (5) step();
        start_i = 1'b1; step(); start_i = 1'b0;
        check("busy_start_ignored", spike_addr_o, 6);
        repeat (4) step();
        check("load_word10", {busy_o, spike_addr_o}, {1'b1, 5'd10});
        abort_i = 1'b1; step(); abort_i = 1'b0;
        check("abort_load_idle", {busy_o, core_valid_o, spike_addr_o}, 0);
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy_o || core_valid_o || irq_o || res_we_o) quiet++;
        end
        check("abort_load_quiet", quiet, 0);
        check("abort_load_flags", {done_o, timeout_o, 5'(wr_log.size())}, 0);

        // Abort in STORE word 3.
        wr_log.delete();
        core_ready_i = 1'b1;
        start_i = 1'b1; step(); start_i = 1'b0;
        hs = -1;
        for (int i = 0; i < 60 && hs < 0; i++) begin
            if (core_valid_o) hs = cyc;
            else step();
        end
        check("store_abort_hs", hs >= 0, 1);
        step(); core_ready_i = 1'b0;
        repeat (4) step();
        core_done_i = 1'b1; step(); core_done_i = 1'b0;
        check("store_word0", {res_we_o, res_addr_o, res_word_o}, {1'b1, 5'd0, exp_words[0]});
        repeat (3) step();
        check("store_word3", {res_we_o, res_addr_o}, {1'b1, 5'd3});
        abort_i = 1'b1; step(); abort_i = 1'b0;
        check("abort_store_idle", {res_we_o, busy_o, res_addr_o}, 0);
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy_o || irq_o || res_we_o) quiet++;
        end
        check("abort_store_quiet", quiet, 0);
        check("abort_store_writes", wr_log.size(), 4);
        check("abort_store_flags", {done_o, timeout_o}, 0);

        // One-cycle reset while waiting for the core.
        core_ready_i = 1'b1;
        start_i = 1'b1; step(); start_i = 1'b0;
        hs = -1;
        for (int i = 0; i < 60 && hs < 0; i++) begin
            if (core_valid_o) hs = cyc;
            else step();
        end
        step(); core_ready_i = 1'b0;
        repeat (3) step();
        check("wait_before_reset", {busy_o, core_valid_o, res_we_o}, {1'b1, 1'b0, 1'b0});
        rst_i = 1'b1; step(); rst_i = 1'b0;
        check("reset_wait_outputs",
              {busy_o, core_valid_o, res_we_o, irq_o, done_o, timeout_o, spike_addr_o, res_addr_o, res_word_o}, 0);
        check("reset_wait_frame", |core_data_o, 0);
        run_frame(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
